// File: rtl/k_and_s_pkg.sv
// ---------------------------------------------------------------------------
// k_and_s_pkg
// Shared types for the K&S datapath: instruction decode enumeration, ALU
// operation encoding, multiplier FSM states, opcode constants and the
// opcode -> decoded_instruction_type lookup.
// Optional feature macro: KS_MUL_EN (opcode A5 decodes to I_MUL only when set).
// ---------------------------------------------------------------------------
package k_and_s_pkg;

    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNEG   = 5'd10,
        I_BOV    = 5'd11,
        I_BNOV   = 5'd12,
        I_BNNEG  = 5'd13,
        I_BNZERO = 5'd14,
        I_HALT   = 5'd15,
        I_MUL    = 5'd16
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_AND    = 3'b001,
        ALU_OR     = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_PASS_A = 3'b100,
        ALU_MUL    = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_MUL    = 8'hA5;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNEG   = 8'h03;
    localparam logic [7:0] OP_BOV    = 8'h05;
    localparam logic [7:0] OP_BNOV   = 8'h06;
    localparam logic [7:0] OP_BNNEG  = 8'h0A;
    localparam logic [7:0] OP_BNZERO = 8'h0B;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    function automatic decoded_instruction_type decode_opcode(input logic [7:0] opcode);
        decoded_instruction_type d;
        case (opcode)
            OP_LOAD:   d = I_LOAD;
            OP_STORE:  d = I_STORE;
            OP_MOVE:   d = I_MOVE;
            OP_ADD:    d = I_ADD;
            OP_SUB:    d = I_SUB;
            OP_AND:    d = I_AND;
            OP_OR:     d = I_OR;
`ifdef KS_MUL_EN
            OP_MUL:    d = I_MUL;
`endif
            OP_BRANCH: d = I_BRANCH;
            OP_BZERO:  d = I_BZERO;
            OP_BNEG:   d = I_BNEG;
            OP_BOV:    d = I_BOV;
            OP_BNOV:   d = I_BNOV;
            OP_BNNEG:  d = I_BNNEG;
            OP_BNZERO: d = I_BNZERO;
            OP_HALT:   d = I_HALT;
            default:   d = I_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ks_mul_unit.sv
// ---------------------------------------------------------------------------
// ks_mul_unit
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Only instantiated when KS_MUL_EN is defined.
//   clk, rst_n : clock / asynchronous active-low reset
//   start      : begin a multiply (ignored unless idle)
//   a, b       : operands, captured on the start edge
//   busy       : high for DATA_W cycles while iterating
//   done       : one-cycle pulse after the last iteration
//   product    : full 2*DATA_W result, held until the next start
// ---------------------------------------------------------------------------
module ks_mul_unit
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    mul_state_t               state;
    logic [CNT_W-1:0]         cnt;
    logic [2*DATA_W-1:0]      mcand;
    logic [DATA_W-1:0]        mplier;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MUL_IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        state   <= MUL_RUN;
                        cnt     <= CNT_W'(DATA_W);
                        mcand   <= {{DATA_W{1'b0}}, a};
                        mplier  <= b;
                        product <= '0;
                        busy    <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    // Last of DATA_W steps: hand over to the one-cycle DONE slot
                    if (cnt == CNT_W'(1)) begin
                        state <= MUL_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                MUL_DONE: begin
                    state <= MUL_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= MUL_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ks_datapath_p.sv
// ---------------------------------------------------------------------------
// ks_datapath_p
// Parametrised K&S datapath: register file, ALU, flags, PC, IR and decoder,
// sequenced externally by the K&S control FSM.
// Optional feature macro: KS_MUL_EN adds the iterative multiplier
// (ks_mul_unit) and the A5 MUL opcode; without it operation 101 acts as
// PASS_A and mul_busy/mul_done stay low.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   branch, pc_enable        PC load (mem field) / increment controls
//   ir_enable                load IR from data_in
//   addr_sel                 ram_addr = PC (1) or IR mem field (0)
//   c_sel                    bus C = data_in (1) or ALU result (0)
//   operation                ALU operation (alu_op_t)
//   write_reg_enable         write bus C into register C
//   flags_reg_enable         load zero/neg/uov/sov flags
//   mul_start/busy/done      multiplier handshake
//   decoded_instruction      decode of the current IR
//   zero_op..signed_overflow flag register outputs
//   ram_addr, data_out       RAM address and store data (bus A)
//   data_in                  RAM read data
// ---------------------------------------------------------------------------
module ks_datapath_p
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  alu_op_t                 operation,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    input  logic                    mul_start,
    output logic                    mul_busy,
    output logic                    mul_done,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    localparam int RSEL_W = $clog2(NREGS);

    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;

    logic [RSEL_W-1:0] ra, rb, rc;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] bus_a, bus_b, bus_c;
    logic [DATA_W-1:0] alu_out;
    logic              alu_uov, alu_sov;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;

    // Fields not selected by any instruction are left unread on purpose
    logic unused_ir;
    assign unused_ir = ^ir;

    function automatic logic add_sov(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic sub_sov(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    // Decode: only fields meaningful to the instruction are passed on
    always_comb begin
        decoded_instruction = decode_opcode(ir[DATA_W-1 -: 8]);
        ra       = '0;
        rb       = '0;
        rc       = '0;
        mem_addr = '0;
        case (decoded_instruction)
            I_LOAD: begin
                rc       = ir[ADDR_W+RSEL_W-1:ADDR_W];
                mem_addr = ir[ADDR_W-1:0];
            end
            I_STORE: begin
                ra       = ir[ADDR_W+RSEL_W-1:ADDR_W];
                mem_addr = ir[ADDR_W-1:0];
            end
            I_MOVE: begin
                ra = ir[RSEL_W-1:0];
                rc = ir[3*RSEL_W-1:2*RSEL_W];
            end
            I_ADD, I_SUB, I_AND, I_OR, I_MUL: begin
                ra = ir[RSEL_W-1:0];
                rb = ir[2*RSEL_W-1:RSEL_W];
                rc = ir[3*RSEL_W-1:2*RSEL_W];
            end
            I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO: begin
                mem_addr = ir[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    assign bus_a    = regs[ra];
    assign bus_b    = regs[rb];
    assign bus_c    = c_sel ? data_in : alu_out;
    assign data_out = bus_a;
    assign ram_addr = addr_sel ? pc : mem_addr;

    assign sum_ext  = {1'b0, bus_a} + {1'b0, bus_b};
    assign diff_ext = {1'b0, bus_a} - {1'b0, bus_b};

`ifdef KS_MUL_EN
    logic                mul_go;
    logic [2*DATA_W-1:0] product;

    assign mul_go = mul_start && (operation == ALU_MUL);

    ks_mul_unit #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_go),
        .a       (bus_a),
        .b       (bus_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );
`else
    logic unused_mul;
    assign unused_mul = mul_start;
    assign mul_busy   = 1'b0;
    assign mul_done   = 1'b0;
`endif

    always_comb begin
        alu_out = bus_a;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        case (operation)
            ALU_ADD: begin
                alu_out = sum_ext[DATA_W-1:0];
                alu_uov = sum_ext[DATA_W];
                alu_sov = add_sov(bus_a[DATA_W-1], bus_b[DATA_W-1], sum_ext[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_out = diff_ext[DATA_W-1:0];
                alu_uov = diff_ext[DATA_W];     // borrow out == (A < B) unsigned
                alu_sov = sub_sov(bus_a[DATA_W-1], bus_b[DATA_W-1], diff_ext[DATA_W-1]);
            end
            ALU_AND:    alu_out = bus_a & bus_b;
            ALU_OR:     alu_out = bus_a | bus_b;
            ALU_PASS_A: alu_out = bus_a;
`ifdef KS_MUL_EN
            ALU_MUL: begin
                alu_out = product[DATA_W-1:0];
                alu_uov = |product[2*DATA_W-1:DATA_W];
            end
`endif
            default:    alu_out = bus_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_reg_enable) begin
            regs[rc] <= bus_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= (alu_out == '0);
            neg_op            <= alu_out[DATA_W-1];
            unsigned_overflow <= alu_uov;
            signed_overflow   <= alu_sov;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (pc_enable) begin
                pc <= branch ? mem_addr : pc + ADDR_W'(1);
            end
            if (ir_enable) begin
                ir <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_ks_datapath_p.sv
module tb_ks_datapath_p;
    import k_and_s_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
    alu_op_t                 operation;
    logic                    write_reg_enable, flags_reg_enable, mul_start;
    logic                    mul_busy, mul_done;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]              ram_addr;
    logic [15:0]             data_out, data_in;

    int n_checks = 0;
    int n_err    = 0;

    ks_datapath_p #(.DATA_W(16), .ADDR_W(5), .NREGS(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .mul_start           (mul_start),
        .mul_busy            (mul_busy),
        .mul_done            (mul_done),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        alu_op_t     op;
        logic [7:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flags;   // {zero, neg, uov, sov}
    } alu_vec_t;

    typedef struct {
        logic [7:0]              opc;
        decoded_instruction_type dec;
    } dec_vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
    } exp_t;

    alu_vec_t alu_vecs[$];
    dec_vec_t dec_vecs[$];
    exp_t     exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_ir(input logic [15:0] v);
        ir_enable = 1'b1;
        data_in   = v;
        step();
        ir_enable = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
        load_ir({OP_LOAD, 1'b0, r, 5'h00});
        c_sel            = 1'b1;
        data_in          = v;
        write_reg_enable = 1'b1;
        step();
        c_sel            = 1'b0;
        write_reg_enable = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [15:0] v);
        load_ir({OP_STORE, 1'b0, r, 5'h00});
        v = data_out;
    endtask

    function automatic logic [31:0] flags_now();
        return 32'({zero_op, neg_op, unsigned_overflow, signed_overflow});
    endfunction

`ifdef KS_MUL_EN
    task automatic mul_run(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_lo, input logic exp_uov,
                           input logic exp_zero, input bit poke);
        int          busy_cnt;
        int          done_cnt;
        bit          got;
        logic [15:0] r;
        busy_cnt = 0;
        done_cnt = 0;
        got      = 0;
        write_reg(2'd0, a);
        write_reg(2'd1, b);
        load_ir({OP_MUL, 8'h24});
        operation = ALU_MUL;
        mul_start = 1'b1;
        step();
        mul_start = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (mul_busy) busy_cnt++;
            if (mul_done) begin
                done_cnt++;
                got              = 1;
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
            end
            mul_start = (poke && c == 4) ? 1'b1 : 1'b0;
            step();
        end
        mul_start        = 1'b0;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
        check("mul_done_seen", 32'(done_cnt), 32'd1);
        check("mul_done_cleared", 32'({mul_busy, mul_done}), 32'd0);
        check("mul_uov", 32'(unsigned_overflow), 32'(exp_uov));
        check("mul_zero", 32'(zero_op), 32'(exp_zero));
        operation = ALU_ADD;
        read_reg(2'd2, r);
        check("mul_result", 32'(r), 32'(exp_lo));
    endtask
`endif

    initial begin
        logic [15:0] v;
        exp_t        e;
        int          act_cnt;

        // Vector tables
        alu_vecs.push_back('{ALU_ADD,    OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101});
        alu_vecs.push_back('{ALU_ADD,    OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010});
        alu_vecs.push_back('{ALU_ADD,    OP_ADD, 16'h1234, 16'h4321, 16'h5555, 4'b0000});
        alu_vecs.push_back('{ALU_SUB,    OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110});
        alu_vecs.push_back('{ALU_SUB,    OP_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b1000});
        alu_vecs.push_back('{ALU_SUB,    OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001});
        alu_vecs.push_back('{ALU_AND,    OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000});
        alu_vecs.push_back('{ALU_OR,     OP_OR,  16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b0100});
        alu_vecs.push_back('{ALU_PASS_A, OP_ADD, 16'h8001, 16'h1234, 16'h8001, 4'b0100});
`ifndef KS_MUL_EN
        alu_vecs.push_back('{ALU_MUL,    OP_ADD, 16'h8123, 16'h0002, 16'h8123, 4'b0100});
`endif

        dec_vecs.push_back('{8'h00, I_NOP});
        dec_vecs.push_back('{8'h81, I_LOAD});
        dec_vecs.push_back('{8'h82, I_STORE});
        dec_vecs.push_back('{8'h91, I_MOVE});
        dec_vecs.push_back('{8'hA1, I_ADD});
        dec_vecs.push_back('{8'hA2, I_SUB});
        dec_vecs.push_back('{8'hA3, I_AND});
        dec_vecs.push_back('{8'hA4, I_OR});
        dec_vecs.push_back('{8'h01, I_BRANCH});
        dec_vecs.push_back('{8'h02, I_BZERO});
        dec_vecs.push_back('{8'h03, I_BNEG});
        dec_vecs.push_back('{8'h05, I_BOV});
        dec_vecs.push_back('{8'h06, I_BNOV});
        dec_vecs.push_back('{8'h0A, I_BNNEG});
        dec_vecs.push_back('{8'h0B, I_BNZERO});
        dec_vecs.push_back('{8'hFF, I_HALT});
        dec_vecs.push_back('{8'h07, I_NOP});
        dec_vecs.push_back('{8'h92, I_NOP});
`ifdef KS_MUL_EN
        dec_vecs.push_back('{8'hA5, I_MUL});
`else
        dec_vecs.push_back('{8'hA5, I_NOP});
`endif

        // Power-on reset
        rst_n = 1'b0;
        branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; addr_sel = 1'b0; c_sel = 1'b0;
        operation = ALU_ADD; write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
        mul_start = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        addr_sel = 1'b1;
        #1;
        check("reset_pc", 32'(ram_addr), 32'd0);
        check("reset_decode", 32'(decoded_instruction), 32'(I_NOP));
        check("reset_flags", flags_now(), 32'd0);
        check("reset_mul", 32'({mul_busy, mul_done}), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        addr_sel = 1'b0;

        // Reset in the middle of a run
        write_reg(2'd1, 16'h1234);
        load_ir({OP_ADD, 8'h24});
        operation        = ALU_PASS_A;
        flags_reg_enable = 1'b1;
        step();
        flags_reg_enable = 1'b0;
        operation        = ALU_ADD;
        pc_enable        = 1'b1;
        repeat (7) step();
        pc_enable = 1'b0;
        addr_sel  = 1'b1;
        #1;
        check("midrst_pre_pc", 32'(ram_addr), 32'd7);
        check("midrst_pre_zero", 32'(zero_op), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pc", 32'(ram_addr), 32'd0);
        check("midrst_decode", 32'(decoded_instruction), 32'(I_NOP));
        check("midrst_flags", flags_now(), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        addr_sel = 1'b0;
        read_reg(2'd1, v);
        check("midrst_r1", 32'(v), 32'd0);

        // PC wrap and branch
        pc_enable = 1'b1;
        repeat (31) step();
        pc_enable = 1'b0;
        addr_sel  = 1'b1;
        #1;
        check("pc_at_31", 32'(ram_addr), 32'd31);
        pc_enable = 1'b1;
        step();
        pc_enable = 1'b0;
        #1;
        check("pc_wrap", 32'(ram_addr), 32'd0);
        addr_sel = 1'b0;
        load_ir({OP_BRANCH, 8'h0A});
        #1;
        check("mem_field", 32'(ram_addr), 32'h0A);
        pc_enable = 1'b1;
        branch    = 1'b1;
        step();
        pc_enable = 1'b0;
        branch    = 1'b0;
        addr_sel  = 1'b1;
        #1;
        check("pc_branch", 32'(ram_addr), 32'h0A);
        addr_sel = 1'b0;

        // Same-cycle write and read of r1
        write_reg(2'd1, 16'h1111);
        load_ir({OP_MOVE, 8'h11});
        c_sel            = 1'b1;
        data_in          = 16'hBEEF;
        write_reg_enable = 1'b1;
        #1;
        check("rw_old_value", 32'(data_out), 32'h1111);
        @(posedge clk);
        #1;
        check("rw_new_value", 32'(data_out), 32'hBEEF);
        @(negedge clk);
        c_sel            = 1'b0;
        write_reg_enable = 1'b0;

        // Decoder table
        foreach (dec_vecs[i]) begin
            load_ir({dec_vecs[i].opc, 8'h00});
            check($sformatf("decode_%02h", dec_vecs[i].opc),
                  32'(decoded_instruction), 32'(dec_vecs[i].dec));
        end

        // ALU table through the scoreboard
        foreach (alu_vecs[i]) begin
            write_reg(2'd0, alu_vecs[i].a);
            write_reg(2'd1, alu_vecs[i].b);
            load_ir({alu_vecs[i].opc, 8'h24});
            operation        = alu_vecs[i].op;
            mul_start        = (alu_vecs[i].op == ALU_MUL);
            write_reg_enable = 1'b1;
            flags_reg_enable = 1'b1;
            exp_q.push_back('{alu_vecs[i].res, alu_vecs[i].flags});
            step();
            write_reg_enable = 1'b0;
            flags_reg_enable = 1'b0;
            mul_start        = 1'b0;
`ifndef KS_MUL_EN
            check($sformatf("alu%0d_no_mul", i), 32'({mul_busy, mul_done}), 32'd0);
`endif
            operation = ALU_ADD;
            e = exp_q.pop_front();
            check($sformatf("alu%0d_flags", i), flags_now(), 32'(e.flags));
            read_reg(2'd2, v);
            check($sformatf("alu%0d_result", i), 32'(v), 32'(e.res));
        end

`ifdef KS_MUL_EN
        mul_run(16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0);
        mul_run(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0);
        mul_run(16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b0, 1'b1);

        // Reset while iterating: no done pulse afterwards
        write_reg(2'd0, 16'h0007);
        write_reg(2'd1, 16'h0009);
        load_ir({OP_MUL, 8'h24});
        operation = ALU_MUL;
        mul_start = 1'b1;
        step();
        mul_start = 1'b0;
        repeat (4) step();
        check("mulrst_pre_busy", 32'(mul_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mulrst_outputs", 32'({mul_busy, mul_done}), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        act_cnt = 0;
        repeat (24) begin
            step();
            if (mul_busy || mul_done) act_cnt++;
        end
        check("mulrst_no_activity", 32'(act_cnt), 32'd0);
        operation = ALU_ADD;
`else
        act_cnt = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
